// File: rtl/seq_arith_pkg.sv
// Shared definitions for the sequential arithmetic blocks (multiplier/divider):
// controller state encoding, default widths and counter sizing.
package seq_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DW_DEF = 8;
    localparam int VW_DEF = 4;

    // The counter must hold the value DW itself, not just DW-1.
    function automatic int cnt_w(input int dw);
        return $clog2(dw + 1);
    endfunction

endpackage

// File: rtl/seq_div_data_path.sv
// Restoring-divider data path: working registers R/Q/D, bit counter,
// trial subtractor and the registered result outputs.
module seq_div_data_path
    import seq_arith_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int VW = VW_DEF
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          load,
    input  logic          step,
    input  logic          commit,
    input  logic          commit_dbz,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero,
    output logic          cnt_last,
    output logic          divisor_zero
);

    localparam int CW = cnt_w(DW);

    logic [VW:0]   r;
    logic [DW-1:0] q;
    logic [VW-1:0] d;
    logic [CW-1:0] cnt;

    logic [VW+1:0] t;
    logic          t_neg;
    logic [VW:0]   r_nxt;
    logic [DW-1:0] q_nxt;

    // R < D holds before every step, so R[VW] is always 0 and the shifted
    // value {R, Q msb} fits VW+1 bits; the extra top bit of T is the borrow.
    always_comb begin
        t     = {r, q[DW-1]} - {2'b00, d};
        t_neg = t[VW+1];
        r_nxt = t_neg ? {r[VW-1:0], q[DW-1]} : t[VW:0];
        q_nxt = {q[DW-2:0], ~t_neg};
    end

    assign cnt_last     = (cnt == CW'(1));
    assign divisor_zero = (divisor == '0);

    always_ff @(posedge clk) begin
        if (clr) begin
            r   <= '0;
            q   <= '0;
            d   <= '0;
            cnt <= '0;
        end else if (load) begin
            r   <= '0;
            q   <= dividend;
            d   <= divisor;
            cnt <= CW'(DW);
        end else if (step) begin
            r   <= r_nxt;
            q   <= q_nxt;
            cnt <= cnt - CW'(1);
        end
    end

    // Results move only when a division completes; commit coincides with the
    // final step, so the next-value of R/Q is what gets published.
    always_ff @(posedge clk) begin
        if (clr) begin
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (commit_dbz) begin
            quotient    <= '1;
            remainder   <= '0;
            div_by_zero <= 1'b1;
        end else if (commit) begin
            quotient    <= q_nxt;
            remainder   <= r_nxt[VW-1:0];
            div_by_zero <= 1'b0;
        end
    end

endmodule

// File: rtl/seq_div.sv
// Sequential restoring divider, one quotient bit per clock; go/done control
// matching the shift-add multiplier. FSM here, arithmetic in the data path.
module seq_div
    import seq_arith_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int VW = VW_DEF
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          go,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          busy,
    output logic          done,
    output logic          div_by_zero
);

    state_t state;
    state_t state_nxt;

    logic load;
    logic step;
    logic commit;
    logic commit_dbz;
    logic cnt_last;
    logic divisor_zero;

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        load       = 1'b0;
        step       = 1'b0;
        commit     = 1'b0;
        commit_dbz = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (go) begin
                    if (divisor_zero) begin
                        commit_dbz = 1'b1;
                        state_nxt  = DONE;
                    end else begin
                        load      = 1'b1;
                        state_nxt = CALC;
                    end
                end
            end
            CALC: begin
                busy = 1'b1;
                step = 1'b1;
                if (cnt_last) begin
                    commit    = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    seq_div_data_path #(
        .DW(DW),
        .VW(VW)
    ) u_data_path (
        .clk         (clk),
        .clr         (clr),
        .load        (load),
        .step        (step),
        .commit      (commit),
        .commit_dbz  (commit_dbz),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .cnt_last    (cnt_last),
        .divisor_zero(divisor_zero)
    );

endmodule
